// File: rtl/acc_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : acc_bin_to_bcd
//  Brief    : Sequential binary-to-BCD converter (shift-and-add-3, one input
//             bit per clock) with a start/busy/done handshake. The most
//             recent result is held on bcd_o between conversions.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_bin_to_bcd #(
    parameter int IN_WIDTH = 17,
    parameter int DIGITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_i,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cat_w = c_bcd_w + IN_WIDTH;
    localparam int c_cnt_w = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(IN_WIDTH - 1);

    // 10^n computed wide enough for any practical DIGITS value
    function automatic logic [127:0] pow10(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 128'd10;
        end
        return r;
    endfunction

    localparam logic [127:0] c_dec_range = pow10(DIGITS);
    localparam logic [127:0] c_bin_max   = (128'd1 << IN_WIDTH) - 128'd1;

    // Refuse to build when DIGITS cannot represent the largest input value
    generate
        if (c_dec_range <= c_bin_max) begin : g_bad_digits
            $error("acc_bin_to_bcd: DIGITS too small for IN_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;

    logic [IN_WIDTH-1:0]  r_shift;
    logic [c_bcd_w-1:0]   r_digits;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_done;
    logic                 r_valid;

    logic [c_bcd_w-1:0]   w_adj;
    logic [c_cat_w-1:0]   w_next_cat;

    // Add-3 correction on every digit that is 5 or more, digits independent
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_adj[4*i +: 4] = (r_digits[4*i +: 4] >= 4'd5) ?
                                     (r_digits[4*i +: 4] + 4'd3) :
                                      r_digits[4*i +: 4];
        end
    endgenerate

    // Corrected digits and the remaining binary bits move left as one word;
    // the binary MSB lands in the LSB of digit 0.
    assign w_next_cat = {w_adj, r_shift} << 1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (r_count == '0) begin
                    w_last       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Working registers and the held result; bcd_o only moves on the final step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_digits <= '0;
            r_count  <= '0;
            r_bcd    <= '0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_shift  <= bin_i;
                r_digits <= '0;
                r_count  <= c_cnt_load;
            end else if (w_step) begin
                r_shift  <= w_next_cat[IN_WIDTH-1:0];
                r_digits <= w_next_cat[c_cat_w-1:IN_WIDTH];
                r_count  <= r_count - 1'b1;
                if (w_last) begin
                    r_bcd   <= w_next_cat[c_cat_w-1:IN_WIDTH];
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign busy  = (r_state == SHIFT);
    assign done  = r_done;
    assign valid = r_valid;
    assign bcd_o = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_acc_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_bin_to_bcd
//  Brief    : Self-checking bench for acc_bin_to_bcd against a decimal
//             arithmetic reference model, directed and random values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_bin_to_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] bin_i;
    logic        busy;
    logic        done;
    logic        valid;
    logic [23:0] bcd_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_bcd;

    acc_bin_to_bcd #(
        .IN_WIDTH (17),
        .DIGITS   (6)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin_i (bin_i),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .bcd_o (bcd_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by plain division, least significant digit in the low nibble
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One conversion: accept v, change bin_i to 'later' afterwards, optionally
    // pulse start=1 (value 1234) at busy cycle 'inj' (negative = none).
    task automatic run_conv(input logic [16:0] v, input logic [16:0] later, input int inj);
        int cyc;
        bit hold_ok;
        @(negedge clk);
        start = 1'b1;
        bin_i = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin_i = later;
        check_val("busy_after_accept", busy, 1);
        cyc = 0;
        hold_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (inj >= 0 && cyc == inj) begin
                start = 1'b1;
                bin_i = 17'd1234;
            end else if (inj >= 0 && cyc == inj + 1) begin
                start = 1'b0;
            end
            if (bcd_o !== exp_bcd) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_val("latency", cyc, 17);
        check_val("hold_during_conv", hold_ok, 1);
        exp_bcd = ref_bcd(32'(v));
        check_val("bcd_result", bcd_o, exp_bcd);
        check_val("valid_after_done", valid, 1);
        check_val("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check_val("done_one_cycle", done, 0);
        check_val("bcd_held", bcd_o, exp_bcd);
    endtask

    initial begin
        int cyc;
        bit hold_ok;
        bit quiet_ok;

        reset = 1'b1;
        start = 1'b0;
        bin_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_bcd", bcd_o, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_bcd = '0;

        // Directed values from the plan, bin_i scrambled after accept
        run_conv(17'd0,      17'($urandom), -1);
        run_conv(17'h1FFFF,  17'($urandom), -1);
        check_val("max_literal", bcd_o, 24'h131071);
        run_conv(17'd99999,  17'($urandom), -1);
        check_val("99999_literal", bcd_o, 24'h099999);
        run_conv(17'd4660,   17'($urandom), -1);
        check_val("4660_literal", bcd_o, 24'h004660);

        // start while busy must be ignored and must not queue
        run_conv(17'd4660, 17'd4660, 5);
        check_val("busy_start_ignored", bcd_o, 24'h004660);
        quiet_ok = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (busy || done) quiet_ok = 1'b0;
        end
        check_val("no_queued_conv", quiet_ok, 1);

        // Input change mid-conversion has no effect
        run_conv(17'd500, 17'd999, -1);
        check_val("captured_at_accept", bcd_o, 24'h000500);

        // Reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1;
        bin_i = 17'd12345;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_valid", valid, 0);
        check_val("midrst_bcd", bcd_o, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_bcd = '0;
        run_conv(17'd7, 17'($urandom), -1);
        check_val("after_rst_7", bcd_o, 24'h000007);

        // Auto-refresh: start held high, value changed after first done
        @(negedge clk);
        start = 1'b1;
        bin_i = 17'd65536;
        cyc = 0;
        hold_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (bcd_o !== exp_bcd) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("auto_first_done", done, 1);
        check_val("auto_hold_1", hold_ok, 1);
        check_val("auto_bcd_1", bcd_o, ref_bcd(32'd65536));
        bin_i = 17'd65535;
        cyc = 0;
        hold_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done && bcd_o !== ref_bcd(32'd65536)) hold_ok = 1'b0;
        end while (!done && cyc < 40);
        start = 1'b0;
        check_val("auto_spacing", cyc, 18);
        check_val("auto_hold_2", hold_ok, 1);
        check_val("auto_bcd_2", bcd_o, ref_bcd(32'd65535));
        exp_bcd = ref_bcd(32'd65535);
        @(posedge clk);
        #1;
        check_val("auto_stopped", busy, 0);

        // Random values across the full input range
        for (int i = 0; i < 20; i++) begin
            run_conv(17'($urandom_range(0, 131071)), 17'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
